// File: rtl/fisr_newton_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fisr_newton_sequencer : magic-constant guess plus ITER Newton-Raphson steps
// for 1/sqrt(x), issued to a shared float32 multiplier and subtractor.
// Revision: 1.0
// ---------------------------------------------------------------------------
module fisr_newton_sequencer #(
    parameter int unsigned ITER  = 1,
    parameter logic [31:0] MAGIC = 32'h5F3759DF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [31:0] x_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        exc,
    output logic        mul_req,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_ack,
    input  logic [31:0] mul_p,
    output logic        sub_req,
    output logic [31:0] sub_a,
    output logic [31:0] sub_b,
    input  logic        sub_ack,
    input  logic [31:0] sub_d
);
    localparam logic [31:0] C_HALF         = 32'h3F000000;
    localparam logic [31:0] C_THREE_HALVES = 32'h3FC00000;
    localparam logic [31:0] C_QNAN         = 32'h7FC00000;
    localparam logic [31:0] C_PINF         = 32'h7F800000;
    localparam logic [1:0]  C_ITER         = 2'(ITER);

    typedef enum logic [2:0] {
        S_IDLE, S_CLASS, S_HALF, S_SQ, S_MX, S_SUB, S_MY, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] x_q, x_d, xh_q, xh_d, y_q, y_d, t_q, t_d;
    logic [31:0] result_q, result_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        req_q, req_d, exc_q, exc_d;
    logic        w_op_mul, w_ack, w_nan;
    logic [31:0] w_res;
    logic [1:0]  w_cnt_inc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            xh_q     <= '0;
            y_q      <= '0;
            t_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            xh_q     <= xh_d;
            y_q      <= y_d;
            t_q      <= t_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            exc_q    <= exc_d;
        end
    end

    assign w_op_mul  = (state_q == S_HALF) || (state_q == S_SQ) ||
                       (state_q == S_MX)   || (state_q == S_MY);
    assign w_ack     = w_op_mul ? mul_ack : sub_ack;
    assign w_res     = w_op_mul ? mul_p : sub_d;
    assign w_nan     = (x_q[30:23] == 8'hFF) && (x_q[22:0] != '0);
    assign w_cnt_inc = cnt_q + 2'd1;

    assign mul_req = req_q & w_op_mul;
    assign sub_req = req_q & (state_q == S_SUB);
    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done    = (state_q == S_DONE);
    assign result  = result_q;
    assign exc     = exc_q;

    // t_q carries t1, t2 and t3 in turn; each is consumed by the next operation.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        sub_a = '0;
        sub_b = '0;
        case (state_q)
            S_HALF:  begin mul_a = x_q;  mul_b = C_HALF; end
            S_SQ:    begin mul_a = y_q;  mul_b = y_q;    end
            S_MX:    begin mul_a = xh_q; mul_b = t_q;    end
            S_SUB:   begin sub_a = C_THREE_HALVES; sub_b = t_q; end
            S_MY:    begin mul_a = y_q;  mul_b = t_q;    end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        xh_d     = xh_q;
        y_d      = y_q;
        t_d      = t_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        exc_d    = exc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x_in;
                    state_d = S_CLASS;
                end
            end
            S_CLASS: begin
                state_d = S_DONE;
                exc_d   = 1'b1;
                if (w_nan || (x_q[31] && (x_q[30:0] != '0))) begin
                    result_d = C_QNAN;
                end else if (x_q[30:23] == 8'h00) begin
                    result_d = C_PINF;
                end else if (x_q[30:23] == 8'hFF) begin
                    result_d = '0;
                end else begin
                    y_d     = MAGIC - (x_q >> 1);
                    cnt_d   = '0;
                    exc_d   = 1'b0;
                    state_d = S_HALF;
                end
            end
            S_HALF, S_SQ, S_MX, S_SUB, S_MY: begin
                // Entry cycle presents operands with req low; req rises next.
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (w_ack) begin
                    req_d = 1'b0;
                    case (state_q)
                        S_HALF:  begin xh_d = w_res; state_d = S_SQ;  end
                        S_SQ:    begin t_d  = w_res; state_d = S_MX;  end
                        S_MX:    begin t_d  = w_res; state_d = S_SUB; end
                        S_SUB:   begin t_d  = w_res; state_d = S_MY;  end
                        default: begin
                            y_d   = w_res;
                            cnt_d = w_cnt_inc;
                            if (w_cnt_inc < C_ITER) begin
                                state_d = S_SQ;
                            end else begin
                                result_d = w_res;
                                state_d  = S_DONE;
                            end
                        end
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_fisr_newton_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fisr_newton_sequencer : two sequencers (ITER=1, ITER=2) against a float
// reference model with a latency-randomized multiplier/subtractor responder.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fisr_newton_sequencer;
    localparam logic [31:0] MAGIC  = 32'h5F3759DF;
    localparam logic [31:0] C_HALF = 32'h3F000000;
    localparam logic [31:0] C_TH   = 32'h3FC00000;

    typedef struct packed {
        logic        m;
        logic [31:0] a;
        logic [31:0] b;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    logic        start[2]     = '{1'b0, 1'b0};
    logic [31:0] x_in[2]      = '{32'h0, 32'h0};
    logic        busy[2], done[2], exc[2], mul_req[2], sub_req[2];
    logic [31:0] result[2], mul_a[2], mul_b[2], sub_a[2], sub_b[2];
    logic        mul_ack[2], sub_ack[2];
    logic [31:0] mul_p[2]     = '{32'h0, 32'h0};
    logic [31:0] sub_d[2]     = '{32'h0, 32'h0};
    logic        r_mul_ack[2] = '{1'b0, 1'b0};
    logic        r_sub_ack[2] = '{1'b0, 1'b0};
    logic        man_ack[2]   = '{1'b0, 1'b0};

    int          lmode[2]   = '{1, 1};
    int          lat_sum[2] = '{0, 0};
    int          exp_n[2]   = '{0, 0};
    int          got_n[2]   = '{0, 0};
    txn_t        exp_txn[2][16];
    logic [31:0] exp_res[2], y0_obs[2];
    logic        exp_exc[2], exp_spec[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        assign mul_ack[gi] = r_mul_ack[gi] | man_ack[gi];
        assign sub_ack[gi] = r_sub_ack[gi];
        fisr_newton_sequencer #(.ITER(gi + 1), .MAGIC(MAGIC)) u_dut (
            .CLK(clk), .RST(rst), .start(start[gi]), .x_in(x_in[gi]),
            .busy(busy[gi]), .done(done[gi]), .result(result[gi]), .exc(exc[gi]),
            .mul_req(mul_req[gi]), .mul_a(mul_a[gi]), .mul_b(mul_b[gi]),
            .mul_ack(mul_ack[gi]), .mul_p(mul_p[gi]),
            .sub_req(sub_req[gi]), .sub_a(sub_a[gi]), .sub_b(sub_b[gi]),
            .sub_ack(sub_ack[gi]), .sub_d(sub_d[gi])
        );
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        int  e;
        real m, v;
        e = int'(f[30:23]);
        m = real'(f[22:0]) / 8388608.0;
        if (e == 0) v = m * (2.0 ** -126.0);
        else        v = (1.0 + m) * (2.0 ** real'(e - 127));
        return f[31] ? -v : v;
    endfunction

    // Round-to-nearest-even double -> float32, normal range only.
    function automatic logic [31:0] r2f(input real v);
        logic [63:0] db;
        int          e;
        logic [23:0] m;
        if (v == 0.0) return 32'h0;
        db = $realtobits(v);
        e  = int'(db[62:52]) - 1023 + 127;
        m  = {1'b0, db[51:29]};
        if (db[28] && ((db[27:0] != '0) || m[0])) m = m + 24'd1;
        if (m[23]) begin
            m = '0;
            e = e + 1;
        end
        return {db[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) * f2r(b));
    endfunction

    function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) - f2r(b));
    endfunction

    task automatic push(input int d, input logic m, input logic [31:0] a, input logic [31:0] b);
        exp_txn[d][exp_n[d]] = '{m, a, b};
        exp_n[d]++;
    endtask

    // Reference: classify, then y <- y*(1.5 - (x/2)*y*y) for d+1 iterations.
    task automatic model(input int d, input logic [31:0] x);
        logic [31:0] xh, y, t;
        exp_n[d]    = 0;
        got_n[d]    = 0;
        exp_spec[d] = 1'b1;
        exp_exc[d]  = 1'b1;
        if ((x[30:23] == 8'hFF && x[22:0] != 0) || (x[31] && x[30:0] != 0))
            exp_res[d] = 32'h7FC00000;
        else if (x[30:23] == 8'h00)
            exp_res[d] = 32'h7F800000;
        else if (x[30:23] == 8'hFF)
            exp_res[d] = 32'h00000000;
        else begin
            exp_spec[d] = 1'b0;
            exp_exc[d]  = 1'b0;
            y  = MAGIC - (x >> 1);
            push(d, 1'b1, x, C_HALF);
            xh = fmul(x, C_HALF);
            for (int it = 0; it <= d; it++) begin
                push(d, 1'b1, y, y);   t = fmul(y, y);
                push(d, 1'b1, xh, t);  t = fmul(xh, t);
                push(d, 1'b0, C_TH, t); t = fsub(C_TH, t);
                push(d, 1'b1, y, t);   y = fmul(y, t);
            end
            exp_res[d] = y;
        end
    endtask

    // Operator stub: acks L cycles after req rises and checks handshake rules.
    initial begin : p_resp
        logic        rq, hm;
        logic [31:0] oa, ob, ha[2], hb[2];
        int          hi_cnt[2], lat[2];
        logic        ack_prev[2];
        hi_cnt   = '{0, 0};
        lat      = '{1, 1};
        ack_prev = '{1'b0, 1'b0};
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                rq = mul_req[d] | sub_req[d];
                hm = mul_req[d];
                oa = hm ? mul_a[d] : sub_a[d];
                ob = hm ? mul_b[d] : sub_b[d];
                r_mul_ack[d] = 1'b0;
                r_sub_ack[d] = 1'b0;
                if (ack_prev[d]) check("req_low_after_ack", rq, 1'b0);
                ack_prev[d] = 1'b0;
                if (rq) begin
                    check("req_exclusive", mul_req[d] & sub_req[d], 1'b0);
                    if (hi_cnt[d] == 0) begin
                        lat[d] = (lmode[d] == 0) ? int'($urandom_range(1, 4)) : lmode[d];
                        ha[d]  = oa;
                        hb[d]  = ob;
                    end else begin
                        check("operand_stable", {oa, ob}, {ha[d], hb[d]});
                    end
                    hi_cnt[d]++;
                    if (hi_cnt[d] == lat[d] + 1) begin
                        if (hm) begin
                            mul_p[d]     = fmul(oa, ob);
                            r_mul_ack[d] = 1'b1;
                        end else begin
                            sub_d[d]     = fsub(oa, ob);
                            r_sub_ack[d] = 1'b1;
                        end
                        ack_prev[d] = 1'b1;
                        lat_sum[d] += lat[d] + 2;
                        if (got_n[d] < exp_n[d])
                            check("txn", {hm, oa, ob}, exp_txn[d][got_n[d]]);
                        else
                            check("txn_extra", got_n[d] + 1, exp_n[d]);
                        if (got_n[d] == 1) y0_obs[d] = oa;
                        got_n[d]++;
                    end
                end else begin
                    hi_cnt[d] = 0;
                end
            end
        end
    end

    // Called and returns on a falling edge; k is the done cycle (start sampled = 0).
    task automatic run(input int d, input logic [31:0] x, input int lm, input bit hold,
                       input logic [31:0] x2, output logic [31:0] res, output int k);
        int t0, nbusy, nreq;
        bit seen;
        model(d, x);
        lmode[d]   = lm;
        lat_sum[d] = 0;
        start[d]   = 1'b1;
        x_in[d]    = x;
        t0    = cyc;
        k     = 0;
        nbusy = 0;
        nreq  = 0;
        seen  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            k = cyc - t0;
            if (!hold) start[d] = 1'b0;
            if (hold && k == 3) x_in[d] = x2;
            if (done[d]) begin
                seen = 1'b1;
                break;
            end
            if (busy[d]) nbusy++;
            if (mul_req[d] || sub_req[d]) nreq++;
        end
        check("done_seen", seen, 1'b1);
        check("done_cycle", k, 2 + lat_sum[d]);
        check("busy_at_done", busy[d], 1'b0);
        check("busy_cycles", nbusy, k - 1);
        check("result", result[d], exp_res[d]);
        check("exc", exc[d], exp_exc[d]);
        check("txn_count", got_n[d], exp_n[d]);
        if (exp_spec[d]) check("special_no_req", nreq, 0);
        else             check("y0", y0_obs[d], MAGIC - (x >> 1));
        res = result[d];
        @(negedge clk);
        check("done_pulse", done[d], 1'b0);
        check("idle_after_done", busy[d], 1'b0);
        check("result_hold", result[d], res);
    endtask

    initial begin : p_main
        logic [31:0] res, xr;
        int          k, d;
        real         r;
        bit          seen;
        repeat (2) @(negedge clk);
        check("rst_flags", {busy[0], done[0], exc[0], mul_req[0], sub_req[0]}, 5'b0);
        check("rst_result", result[0], 32'h0);
        check("rst_mul_ops", {mul_a[0], mul_b[0]}, 64'h0);
        check("rst_sub_ops", {sub_a[0], sub_b[0]}, 64'h0);
        rst = 1'b0;

        run(0, 32'h3F800000, 1, 1'b0, 32'h0, res, k);
        check("one_done17", k, 17);
        r = f2r(res);
        check("one_range", (r >= 0.9980 && r <= 0.9986), 1'b1);

        run(1, 32'h42F6E979, 0, 1'b0, 32'h0, res, k);
        r = f2r(res) - 0.09;
        check("x123_range", (r < 1.0e-4 && r > -1.0e-4), 1'b1);

        run(0, 32'hC0000000, 1, 1'b0, 32'h0, res, k);
        check("neg_done2", k, 2);
        check("neg_qnan", res, 32'h7FC00000);
        run(0, 32'h80000000, 1, 1'b0, 32'h0, res, k);
        check("negzero_inf", res, 32'h7F800000);
        run(0, 32'h7F800000, 1, 1'b0, 32'h0, res, k);
        check("inf_zero", res, 32'h0);

        // start held and x_in changed while busy; re-accepted only from IDLE
        run(0, 32'h40400000, 1, 1'b1, 32'h41100000, res, k);
        r = f2r(res);
        check("hold_first_range", (r >= 0.570 && r <= 0.580), 1'b1);
        run(0, 32'h41100000, 1, 1'b0, 32'h0, res, k);
        r = f2r(res);
        check("hold_second_range", (r >= 0.330 && r <= 0.3345), 1'b1);

        // reset while the MX multiply is requested
        model(0, 32'h3F800000);
        lmode[0] = 3;
        start[0] = 1'b1;
        x_in[0]  = 32'h3F800000;
        seen     = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (mul_req[0] && got_n[0] == 2) begin
                seen = 1'b1;
                break;
            end
        end
        check("mx_reached", seen, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("arst_flags", {busy[0], done[0], exc[0], mul_req[0], sub_req[0]}, 5'b0);
        check("arst_result", result[0], 32'h0);
        check("arst_ops", {mul_a[0], mul_b[0], sub_a[0]}, 96'h0);
        man_ack[0] = 1'b1;
        @(negedge clk);
        man_ack[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("late_ack_ignored", {busy[0], done[0], mul_req[0], sub_req[0]}, 4'b0);
            @(negedge clk);
        end

        run(0, 32'h40800000, 3, 1'b0, 32'h0, res, k);
        check("four_done27", k, 27);
        r = f2r(res);
        check("four_range", (r >= 0.4990 && r <= 0.4995), 1'b1);

        for (int n = 0; n < 10; n++) begin
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) xr = $urandom;
            else xr = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            run(d, xr, 0, 1'b0, 32'h0, res, k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "time limit");
    end
endmodule
`default_nettype wire

// File: doc/fisr_newton_sequencer.md
# fisr_newton_sequencer

Control sequencer for the FISR FPU's Newton-Raphson refinement of 1/sqrt(x). It takes a float32 operand, forms the magic-constant initial guess internally, and sequences ITER refinement iterations. Each iteration is issued as operations to a shared float32 multiplier and float32 subtractor over req/ack handshakes. It sits between the decimal-entry front end, which supplies the float32 operand and start, and the display back end, which consumes the result and done.

## Interface
- ITER, 1, Newton iterations performed (legal 1..3)
- MAGIC, 32'h5F3759DF, initial-guess constant
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- x_in  in  32  float32 operand; captured when start is accepted
- busy  out  1  high while a computation is in progress
- done  out  1  one-cycle pulse, result valid
- result  out  32  float32 1/sqrt(x); held until next done
- exc  out  1  special-case input flag; updated with done
- mul_req  out  1  multiplier request
- mul_a, mul_b  out  32 each  multiplier operands
- mul_ack  in  1  multiplier completion
- mul_p  in  32  product; valid when mul_ack=1
- sub_req  out  1  subtractor request
- sub_a, sub_b  out  32 each  subtractor operands, computing a-b
- sub_ack  in  1  subtractor completion
- sub_d  in  32  difference; valid when sub_ack=1

## Operation
- States: IDLE, CLASS, HALF, SQ, MX, SUB, MY, DONE.
- IDLE: start=1 latches x_in, goes to CLASS. start is ignored in every other state.
- CLASS: classifies x.
  - Sign=1 with nonzero magnitude, or NaN: result=32'h7FC00000, exc=1.
  - Exponent field 0 (±0, denormal): result=32'h7F800000, exc=1.
  - +inf: result=32'h00000000, exc=1.
  - Any special case goes straight to DONE and issues no requests.
  - Otherwise: y = MAGIC - (x>>1), unsigned 32-bit, modulo 2^32. Go to HALF. Clear iteration counter and exc.
- Operation sequence (port: a, b -> destination register):
  - HALF (mul): x, 32'h3F000000 -> xh
  - SQ (mul): y, y -> t1
  - MX (mul): xh, t1 -> t2
  - SUB (sub): 32'h3FC00000, t2 -> t3
  - MY (mul): y, t3 -> y
- After MY: counter+1. If counter < ITER, go to SQ; else go to DONE.
- DONE: done=1 and result=y for one cycle, then IDLE.
- Total operations per run: 1 + 4*ITER.

## Timing
- Reset (RST=1 at a rising edge): state IDLE. busy, done, exc, mul_req, sub_req = 0. result and all operand outputs = 32'h0. Counter = 0.
- Reset mid-operation: abort next cycle, both req low, no done. A late ack after reset is ignored.
- Per-operation handshake:
  - Entry cycle of an op state: req=0, operands driven.
  - Next cycle: req=1.
  - req and operands stay stable until the cycle where ack=1 is sampled. Result is captured that cycle and the state advances.
  - ack with req=0 is ignored.
  - Each operation therefore costs L+2 cycles, where L>=1 is the number of cycles from req rise to ack.
  - Only one of mul_req/sub_req is ever high.
- Normal timeline (cycle 0 = start sampled):
  - CLASS in cycle 1; busy=1 from cycle 1.
  - done in cycle 2+(L+2)(1+4*ITER).
  - For L=1, ITER=1: done in cycle 17, busy high cycles 1..16. busy=0 in the done cycle; IDLE at cycle 18.
- Special-case input: done in cycle 2, busy high only in cycle 1.
- start high during DONE is ignored. It is accepted the next cycle in IDLE if still high.

## Test plan
- x_in=32'h3F800000 (1.0), ITER=1, ack L=1 -> y after CLASS=32'h3F7759DF; HALF operands {3F800000,3F000000}; done at cycle 17; result in [0.9980,0.9986]; exc=0.
- x_in=32'h42F6E979 (123.456), ITER=2, random L in 1..4 -> exactly 9 ack'd transactions in order HALF,SQ,MX,SUB,MY,SQ,MX,SUB,MY; result within 1e-4 of 0.090000; req never high across an ack+1 cycle.
- x_in=32'hC0000000 (-2.0) -> no req ever asserted; done at cycle 2; result=32'h7FC00000; exc=1. x_in=32'h80000000 -> result=32'h7F800000, exc=1.
- start held high and x_in changed while busy -> single done; result matches the first operand; the second start is accepted only after returning to IDLE.
- RST=1 for one cycle during MX with mul_req=1 -> next cycle all outputs at reset values; a mul_ack pulsed after reset produces no state change and no done.
- x_in=32'h40800000 (4.0), ITER=1, L=3 -> y0=32'h3EF759DF; done at cycle 27; result in [0.4990,0.4995].
